keypad_scanner_fifo: RTL and testbench

KEYPAD_SCANNER_FIFO -- requirements
Module: keypad_scanner_fifo

---
 rtl/keypad_pkg.sv | 7 +
 rtl/kp_event_fifo.sv | 37 +++
 rtl/keypad_scanner_fifo.sv | 136 +++++++++++++
 tb/tb_keypad_scanner_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding and code-width helper for the keypad scanner.
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} kp_state_e;
  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction
endpackage

// File: rtl/kp_event_fifo.sv
// kp_event_fifo: power-of-2 event buffer with ready/valid pop; head reads zero when empty.
module kp_event_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;
  logic         w_pop, w_wr;
  // extra pointer bit distinguishes full from empty
  always_comb begin
    o_empty = r_wr == r_rd;
    o_full  = r_wr == {~r_rd[AW], r_rd[AW-1:0]};
    w_pop   = !o_empty && i_ready;
    w_wr    = i_push && (!o_full || w_pop);
    o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + {{AW{1'b0}}, w_wr};
      r_rd <= r_rd + {{AW{1'b0}}, w_pop};
    end
  end
  always_ff @(posedge clk) if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/keypad_scanner_fifo.sv
// keypad_scanner_fifo: column-scanned keypad with ghost rejection, frame-based debounce,
// autorepeat and a buffered event queue.
module keypad_scanner_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int SCAN_DIV    = 64,
  parameter int DEB_CNT     = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int REPEAT_DLY  = 16,
  parameter int REPEAT_RATE = 4,
  localparam int KW         = code_width(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            resetn,
  output logic [COLS-1:0] col_drv,
  input  logic [ROWS-1:0] row_in,
  input  logic            repeat_en,
  input  logic            clr_ovf,
  output logic [KW-1:0]   key_code,
  output logic            key_repeat,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overflow
);
  localparam int DIVW = $clog2(SCAN_DIV + 1);
  localparam int CW   = $clog2(COLS + 1);
  localparam int NW   = $clog2(DEB_CNT + 1);
  localparam int TW   = $clog2(REPEAT_DLY + 1);
  logic [ROWS-1:0] r_sync1, r_sync2;
  logic [DIVW-1:0] r_div;
  logic [CW-1:0]   r_col;
  logic [1:0]      r_nkeys, w_col_n, w_tot;
  logic [KW-1:0]   r_code, r_cand, w_col_code, w_code;
  logic [NW-1:0]   r_cnt;
  logic [TW-1:0]   r_rpt;
  logic            r_ovf;
  kp_state_e       r_state, w_next;
  logic            w_step_end, w_frame_end, w_hit, w_single, w_fire;
  logic            w_push, w_push_rpt, w_drop, w_full, w_empty;
  logic [KW:0]     w_head;
  // key count saturates at 2: anything above one key is a ghost/NONE frame
  always_comb begin
    w_step_end  = r_div == DIVW'(SCAN_DIV - 1);
    w_frame_end = w_step_end && r_col == CW'(COLS - 1);
    w_col_n     = '0;
    w_col_code  = '0;
    for (int r = 0; r < ROWS; r++)
      if (!r_sync2[r]) begin
        w_col_n    = (w_col_n == 2'd2) ? 2'd2 : w_col_n + 2'd1;
        w_col_code = KW'(r * COLS) + KW'(r_col);
      end
    w_tot    = (r_nkeys == 2'd0) ? w_col_n : (w_col_n == 2'd0) ? r_nkeys : 2'd2;
    w_code   = (w_col_n != 2'd0) ? w_col_code : r_code;
    w_single = w_tot == 2'd1;
    w_hit    = w_single && w_code == r_cand;
    w_fire   = r_rpt == TW'(REPEAT_DLY - 1);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_div   <= '0;
      r_col   <= '0;
      r_nkeys <= '0;
      r_code  <= '0;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
      r_div   <= w_step_end ? '0 : r_div + DIVW'(1);
      if (w_step_end) begin
        r_col   <= (r_col == CW'(COLS - 1)) ? '0 : r_col + CW'(1);
        r_nkeys <= w_frame_end ? '0 : w_tot;
        r_code  <= w_code;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_rpt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_frame_end) begin
        r_cnt <= (r_state == IDLE || r_state == HELD) ? NW'(1) : r_cnt + NW'(1);
        if (r_state == IDLE) r_cand <= w_code;
        r_rpt <= (r_state == DEBOUNCE) ? '0 :
                 (r_state != HELD || !w_hit) ? r_rpt :
                 !repeat_en ? '0 :
                 w_fire ? TW'(REPEAT_DLY - REPEAT_RATE) : r_rpt + TW'(1);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (w_frame_end)
      case (r_state)
        IDLE:     w_next = w_single ? DEBOUNCE : IDLE;
        DEBOUNCE: w_next = !w_hit ? IDLE : (r_cnt == NW'(DEB_CNT - 1)) ? HELD : DEBOUNCE;
        HELD:     w_next = w_hit ? HELD : RELEASE;
        RELEASE:  w_next = w_hit ? HELD : (r_cnt == NW'(DEB_CNT - 1)) ? IDLE : RELEASE;
        default:  w_next = IDLE;
      endcase
  end
  always_comb begin
    col_drv    = ~(COLS'(1) << r_col);
    key_held   = r_state == HELD;
    w_push_rpt = w_frame_end && r_state == HELD && w_hit && repeat_en && w_fire;
    w_push     = w_push_rpt ||
                 (w_frame_end && r_state == DEBOUNCE && w_hit && r_cnt == NW'(DEB_CNT - 1));
    w_drop     = w_push && w_full && !(key_valid && key_ready);
    key_valid  = !w_empty;
    key_code   = w_head[KW-1:0];
    key_repeat = w_head[KW];
    overflow   = r_ovf;
  end
  // a drop in the same cycle as clr_ovf wins so no loss goes unreported
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_ovf <= 1'b0;
    else r_ovf <= w_drop ? 1'b1 : clr_ovf ? 1'b0 : r_ovf;
  end
  kp_event_fifo #(.W(KW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .i_push (w_push),
    .i_data ({w_push_rpt, r_cand}),
    .i_ready(key_ready),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// tb_keypad_scanner_fifo: frame-stepped keypad matrix stimulus checked against a
// frame-level behavioural model plus fixed expectation tables.
module tb_keypad_scanner_fifo;
  localparam int DIV = 64, DEB = 4, DEPTH = 4, DLY = 16, RATE = 4, FR = 4 * DIV;
  logic clk = 0, resetn = 0, repeat_en = 0, clr_ovf = 0, key_ready = 1;
  logic [3:0] col_drv, row_in, key_code;
  logic key_repeat, key_valid, key_held, overflow;
  logic [15:0] keys = '0;
  int cyc, n_pass, n_tot;
  int ev, evf, ec, er;
  int m_cand, m_run, m_held, m_rel, m_age, m_ovf;
  typedef struct {int code; bit rpt;} ev_t;
  ev_t q[$];
  typedef struct {logic [15:0] keys; int frames; int n_ev; int ev_frame; int code; bit held;} vec_t;
  vec_t vt[7];
  logic [15:0] tg[9];
  int exp_f[6];
  int ovc[6];
  int rf[$];
  int rr[$];

  keypad_scanner_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(DIV), .DEB_CNT(DEB), .FIFO_DEPTH(DEPTH),
    .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .resetn(resetn), .col_drv(col_drv), .row_in(row_in), .repeat_en(repeat_en),
    .clr_ovf(clr_ovf), .key_code(key_code), .key_repeat(key_repeat), .key_valid(key_valid),
    .key_ready(key_ready), .key_held(key_held), .overflow(overflow));

  always #5 clk = ~clk;
  // switch matrix: a pressed key pulls its row low while its column is driven
  always_comb for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_drv);
  always @(posedge clk or negedge resetn) if (!resetn) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(input string n, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", n, got, exp, $time);
  endtask

  function automatic void m_reset();
    m_cand = -1; m_run = 0; m_held = 0; m_rel = 0; m_age = 0; m_ovf = 0;
    q.delete();
  endfunction

  // one frame of keypad behaviour from the rules: single key or NONE, debounce runs,
  // release runs, repeats at DLY, DLY+RATE, ... frames of holding after acceptance
  function automatic void m_frame(input logic [15:0] k, input bit rep, input bit pop_end);
    int n = 0, res = -1;
    bit push = 0;
    ev_t e;
    for (int i = 0; i < 16; i++) if (k[i]) begin n++; res = i; end
    if (n != 1) res = -1;
    e = '{res, 1'b0};
    if (m_held == 0) begin
      if (m_run == 0) begin
        if (res >= 0) begin m_cand = res; m_run = 1; end
      end else if (res == m_cand) begin
        m_run++;
        if (m_run == DEB) begin m_held = 1; m_rel = 0; m_age = 0; push = 1; end
      end else m_run = 0;
    end else if (res == m_cand) begin
      if (m_rel > 0) m_rel = 0;
      else if (!rep) m_age = 0;
      else begin
        m_age++;
        if (m_age >= DLY && (m_age - DLY) % RATE == 0) begin push = 1; e.rpt = 1; end
      end
    end else begin
      m_rel++;
      if (m_rel == DEB) begin m_held = 0; m_run = 0; end
    end
    if (pop_end && q.size() > 0) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(e);
      else m_ovf = 1;
    end
  endfunction

  task automatic frame(input logic [15:0] k, input bit rdy_end = 0);
    bit pe;
    keys = k;
    if (key_ready) q.delete();
    do begin
      @(posedge clk); #1;
      if (rdy_end && cyc % FR == FR - 1) key_ready = 1;
    end while (cyc % FR != 0);
    pe = key_ready;
    m_frame(k, repeat_en, pe);
    chk("valid", key_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("code", key_code, q[0].code);
      chk("repeat", key_repeat, q[0].rpt);
    end
    chk("held", key_held, m_held != 0 && m_rel == 0);
    chk("overflow", overflow, m_ovf);
    if (rdy_end) key_ready = 0;
  endtask

  task automatic drain();
    key_ready = 1;
    while (q.size() > 0) begin
      chk("drain_valid", key_valid, 1);
      chk("drain_code", key_code, q[0].code);
      chk("drain_repeat", key_repeat, q[0].rpt);
      void'(q.pop_front());
      @(posedge clk); #1;
    end
    chk("drained", key_valid, 0);
  endtask

  initial begin
    vt[0] = '{16'h0200, 10, 1, 4, 9, 1'b1};
    vt[1] = '{16'h8001, 10, 0, 0, 0, 1'b0};
    vt[2] = '{16'h0001, 5, 1, 4, 0, 1'b1};
    vt[3] = '{16'h8000, 4, 1, 4, 15, 1'b1};
    vt[4] = '{16'h0040, 3, 0, 0, 0, 1'b0};
    vt[5] = '{16'h0030, 6, 0, 0, 0, 1'b0};
    vt[6] = '{16'h0440, 6, 0, 0, 0, 1'b0};
    tg = '{16'h0020, 16'h0000, 16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020};
    exp_f = '{4, 20, 24, 28, 32, 36};
    ovc = '{1, 2, 7, 8, 11, 14};
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_col_drv", col_drv, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_repeat", key_repeat, 0);
    chk("rst_held", key_held, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk) resetn = 1;
    // fixed single-key, ghost and short-press patterns
    foreach (vt[i]) begin
      ev = 0; evf = -1; ec = -1; er = -1;
      for (int f = 1; f <= vt[i].frames; f++) begin
        frame(vt[i].keys);
        if (key_valid) begin
          ev++;
          if (evf < 0) begin evf = f; ec = key_code; er = key_repeat; end
        end
      end
      chk("tbl_events", ev, vt[i].n_ev);
      if (vt[i].n_ev > 0) begin
        chk("tbl_ev_frame", evf, vt[i].ev_frame);
        chk("tbl_ev_code", ec, vt[i].code);
        chk("tbl_ev_repeat", er, 0);
      end
      chk("tbl_held", key_held, vt[i].held);
      repeat (DEB) frame('0);
    end
    // bouncy key 5
    ev = 0; ec = -1;
    foreach (tg[i]) begin
      frame(tg[i]);
      if (key_valid) begin ev++; ec = key_code; end
    end
    chk("bounce_events", ev, 1);
    chk("bounce_code", ec, 5);
    repeat (DEB) frame('0);
    // autorepeat on key 3
    repeat_en = 1;
    for (int f = 1; f <= 38; f++) begin
      frame(16'h0008);
      if (key_valid) begin rf.push_back(f); rr.push_back(int'(key_repeat)); end
    end
    chk("rpt_count", rf.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < rf.size()) begin
        chk("rpt_frame", rf[i], exp_f[i]);
        chk("rpt_flag", rr[i], i > 0);
      end
    repeat_en = 0;
    repeat (DEB) frame('0);
    // six presses into a stalled consumer
    key_ready = 0;
    foreach (ovc[i]) begin
      repeat (DEB) frame(16'(1) << ovc[i]);
      repeat (DEB) frame('0);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_head", key_code, 1);
    @(negedge clk) clr_ovf = 1;
    @(negedge clk) clr_ovf = 0;
    m_ovf = 0;
    chk("ovf_clr", overflow, 0);
    // full FIFO: pop and push on the same edge both succeed
    repeat (DEB - 1) frame(16'h1000);
    frame(16'h1000, 1);
    chk("pp_overflow", overflow, 0);
    chk("pp_head", key_code, 2);
    chk("pp_depth", q.size(), 4);
    drain();
    repeat (DEB) frame('0);
    // reset with two events queued and a key still down
    key_ready = 0;
    repeat (DEB) frame(16'h0400);
    repeat (DEB) frame('0);
    repeat (DEB) frame(16'h2000);
    chk("prerst_valid", key_valid, 1);
    repeat (100) @(posedge clk);
    @(negedge clk) resetn = 0;
    #1;
    chk("arst_valid", key_valid, 0);
    chk("arst_held", key_held, 0);
    chk("arst_code", key_code, 0);
    @(negedge clk) resetn = 1;
    m_reset();
    key_ready = 1;
    evf = -1;
    for (int f = 1; f <= 6; f++) begin
      frame(16'h2000);
      if (key_valid && evf < 0) begin evf = f; ec = key_code; end
    end
    chk("rerun_frame", evf, DEB);
    chk("rerun_code", ec, 13);
    repeat (DEB) frame('0);
    // randomized segments against the model
    for (int s = 0; s < 10; s++) begin
      int kind, a, n;
      logic [15:0] k;
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 15);
      k = '0;
      if (kind > 0) k[a] = 1'b1;
      if (kind == 2) k[(a + $urandom_range(1, 15)) % 16] = 1'b1;
      n = $urandom_range(1, 8);
      repeat_en = 1'($urandom_range(0, 1));
      key_ready = 1'($urandom_range(0, 1));
      repeat (n) frame(k);
    end
    drain();
    @(negedge clk) clr_ovf = 1;
    @(negedge clk) clr_ovf = 0;
    chk("final_ovf_clr", overflow, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
